// File: rtl/image_pkg.sv
// Shared image constants and FSM encoding for the frame-buffer
// read and write units.
package image_pkg;

    localparam int IMG_DATA_WIDTH = 8;
    localparam int IMG_ADDR_WIDTH = 14;
    localparam int IMG_WIDTH      = 128;
    localparam int IMG_HEIGHT     = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FINISH  = 2'd2
    } img_state_t;

    // A 1-wide counter is still needed for a 1-entry extent.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: x fastest, wraps into y, and holds
// once the last position of the frame is reached.
module raster_counter
    import image_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int XW     = cnt_width(WIDTH),
    parameter int YW     = cnt_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    logic x_end;

    assign x_end = (x == XMAX);
    assign last  = x_end && (y == YMAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (step && !last) begin
            if (x_end) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_write_unit.sv
// Captures one raster-order frame into a column-major frame buffer
// (address = x*HEIGHT + y) with registered write strobes.
module image_write_unit
    import image_pkg::*;
#(
    parameter int DATA_WIDTH = IMG_DATA_WIDTH,
    parameter int ADDR_WIDTH = IMG_ADDR_WIDTH,
    parameter int WIDTH      = IMG_WIDTH,
    parameter int HEIGHT     = IMG_HEIGHT
) (
    input  logic                  wClk,
    input  logic                  wRst,
    input  logic                  start,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iLast,
    output logic                  oReady,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0] wd,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int XW = cnt_width(WIDTH);
    localparam int YW = cnt_width(HEIGHT);

    img_state_t state, state_nx;

    logic          accept;
    logic          clr;
    logic          cnt_last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic [ADDR_WIDTH-1:0] addr;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_cnt (
        .clk  (wClk),
        .rst  (wRst),
        .clr  (clr),
        .step (accept),
        .x    (x),
        .y    (y),
        .last (cnt_last)
    );

    always_ff @(posedge wClk) begin
        if (wRst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        oReady   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                oReady = 1'b1;
                busy   = 1'b1;
                if (iValid && cnt_last) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign accept = oReady && iValid;

    // Column-major so the read side can scan by x*HEIGHT + y.
    assign addr = ADDR_WIDTH'(x) * ADDR_WIDTH'(HEIGHT)
                + ADDR_WIDTH'(y);

    always_ff @(posedge wClk) begin
        if (wRst) begin
            we  <= 1'b0;
            wa  <= '0;
            wd  <= '0;
            err <= 1'b0;
        end else begin
            we <= accept;
            if (accept) begin
                wa <= addr;
                wd <= iData;
            end
            // Source framing is only reported; position count rules.
            if (clr) begin
                err <= 1'b0;
            end else if (accept && (iLast != cnt_last)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_write_unit.sv
// Randomized bench for image_write_unit against a raster-to-
// column-major reference model.
module tb_image_write_unit;

    localparam int W = 128;
    localparam int H = 128;
    localparam int N = W * H;
    localparam int BW = 4;
    localparam int BH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ivalid, ilast;
    logic [7:0]  idata;
    logic        ready, we, busy, done, err;
    logic [13:0] wa;
    logic [7:0]  wd;

    logic        b_rst, b_start, b_ivalid, b_ilast;
    logic [7:0]  b_idata;
    logic        b_ready, b_we, b_busy, b_done, b_err;
    logic [13:0] b_wa;
    logic [7:0]  b_wd;

    image_write_unit dut (
        .wClk   (clk),
        .wRst   (rst),
        .start  (start),
        .iValid (ivalid),
        .iData  (idata),
        .iLast  (ilast),
        .oReady (ready),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    image_write_unit #(
        .WIDTH  (BW),
        .HEIGHT (BH)
    ) dut_small (
        .wClk   (clk),
        .wRst   (b_rst),
        .start  (b_start),
        .iValid (b_ivalid),
        .iData  (b_idata),
        .iLast  (b_ilast),
        .oReady (b_ready),
        .we     (b_we),
        .wa     (b_wa),
        .wd     (b_wd),
        .busy   (b_busy),
        .done   (b_done),
        .err    (b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pixel k arrives raster order; the buffer is column-major.
    function automatic int exp_addr(input int k, input int w,
                                    input int h);
        return (k % w) * h + (k / w);
    endfunction

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] exp_wa[$];
    logic [7:0]  exp_wd[$];
    int          hits[N];
    logic [7:0]  mem[N];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          done_we = 0;
    int          last_cyc = 0;

    logic [13:0] b_got[$];
    int          b_done_cnt = 0;

    always @(negedge clk) begin
        if (we) begin
            wr_cnt++;
            check("write_expected", exp_wa.size() != 0, 1);
            if (exp_wa.size() != 0) begin
                check("wa", wa, exp_wa.pop_front());
                check("wd", wd, exp_wd.pop_front());
            end
            hits[wa]++;
            mem[wa] = wd;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_we  = we;
        end
        if (b_we) b_got.push_back(b_wa);
        if (b_done) b_done_cnt++;
    end

    task automatic frame(input int duty, input int bad_last,
                         input bit idx_data, input bit poke);
        int         k = 0;
        int         missing = 0;
        bit         just_bad;
        logic [7:0] d;
        foreach (hits[i]) hits[i] = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_after_start", err, 0);
        while (k < N) begin
            just_bad = 0;
            start    = 1'b0;
            if ($urandom_range(99) < duty) begin
                d = idx_data ? 8'(k) : 8'($urandom);
                ivalid = 1'b1;
                idata  = d;
                ilast  = (k == N - 1) || (k == bad_last);
                if (k == bad_last) begin
                    check("err_before_bad", err, 0);
                    just_bad = 1;
                end
                if (k % 1024 == 0) check("ready_capture", ready, 1);
                exp_wa.push_back(14'(exp_addr(k, W, H)));
                exp_wd.push_back(d);
                last_cyc = cyc;
                k++;
            end else begin
                ivalid = 1'b0;
                ilast  = 1'($urandom_range(1));
                idata  = 8'($urandom);
            end
            if (poke && k == N / 3) start = 1'b1;
            @(negedge clk);
            if (just_bad) check("err_after_bad", err, 1);
        end
        ivalid = 1'b0;
        ilast  = 1'b0;
        check("busy_finish", busy, 0);
        check("ready_finish", ready, 0);
        check("done_finish", done, 1);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        repeat (3) @(negedge clk);
        check("busy_after_frame", busy, 0);
        check("writes", wr_cnt, N);
        check("done_count", done_cnt, 1);
        check("done_timing", done_cyc, last_cyc + 1);
        check("done_with_last_we", done_we, 1);
        foreach (hits[i]) if (hits[i] != 1) missing++;
        check("addr_coverage", missing, 0);
        check("queue_drained", exp_wa.size(), 0);
        check("err_end", err, bad_last >= 0);
        exp_wa.delete();
        exp_wd.delete();
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; ivalid = 1'b0; ilast = 1'b0;
        idata = '0;
        b_rst = 1'b1; b_start = 1'b0; b_ivalid = 1'b0;
        b_ilast = 1'b0; b_idata = '0;
        ivalid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 0);
        ivalid = 1'b0;
        rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);

        frame(100, -1, 1, 0);
        check("pixel_5_2", mem[5 * H + 2], 8'(2 * W + 5));

        wr_cnt = 0;
        ivalid = 1'b1;
        repeat (10) begin
            idata = 8'($urandom);
            @(negedge clk);
        end
        check("idle_ready", ready, 0);
        ivalid = 1'b0;
        @(negedge clk);
        check("idle_no_write", wr_cnt, 0);

        frame(50, -1, 0, 1);
        frame(100, 100, 0, 0);

        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_by_start", err, 0);
        for (k = 0; k < 5000; k++) begin
            ivalid = 1'b1;
            idata  = 8'($urandom);
            ilast  = 1'b0;
            exp_wa.push_back(14'(exp_addr(k, W, H)));
            exp_wd.push_back(idata);
            @(negedge clk);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        ivalid = 1'b0;
        check("midrst_we", we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        check("midrst_wa", wa, 0);
        check("midrst_queue", exp_wa.size(), 0);
        repeat (4) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ivalid = 1'b1;
        idata  = 8'hA5;
        exp_wa.push_back(14'(exp_addr(0, W, H)));
        exp_wd.push_back(8'hA5);
        @(negedge clk);
        ivalid = 1'b0;
        check("restart_we", we, 1);
        check("restart_wa", wa, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (k < BW * BH) begin
            if ($urandom_range(1) == 1) begin
                b_ivalid = 1'b1;
                b_idata  = 8'($urandom);
                b_ilast  = (k == BW * BH - 1);
                k++;
            end else begin
                b_ivalid = 1'b0;
                b_ilast  = 1'b0;
            end
            @(negedge clk);
        end
        b_ivalid = 1'b0;
        b_ilast  = 1'b0;
        repeat (3) @(negedge clk);
        check("small_writes", b_got.size(), BW * BH);
        for (int i = 0; i < BW * BH; i++) begin
            if (i < b_got.size())
                check("small_addr", b_got[i], exp_addr(i, BW, BH));
        end
        check("small_done", b_done_cnt, 1);
        check("small_err", b_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
